// File: rtl/multi_cycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl_if : controller <-> datapath/memory signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface multi_cycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             bcond;
  logic             halt_cond;
  logic             mem_ready;
  logic             mem_read;
  logic             mem_write;
  logic             i_or_d;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_source;
  logic             reg_write;
  logic [1:0]       mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             is_halted;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, bcond, halt_cond, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
           reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           is_halted, state, retired
  );

  modport slave (
    output opcode, bcond, halt_cond, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
           reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           is_halted, state, retired
  );
endinterface

`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl : IF/ID/EX/MEM/WB sequencing FSM for the multi-cycle RV32I core
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multi_cycle_ctrl #(
  parameter bit HALT_ON_UNKNOWN = 1'b0,
  parameter int CNT_W           = 32
) (
  input  wire logic           clk,
  input  wire logic           reset,
  multi_cycle_ctrl_if.master  bus_if
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_IARITH = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_ECALL  = 7'b1110011;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic       w_mem_read, w_mem_write, w_i_or_d, w_ir_write, w_pc_write;
  logic       w_reg_write, w_alu_src_a, w_known;
  logic [1:0] w_pc_source, w_mem_to_reg, w_alu_src_b, w_alu_op;

  always_comb begin
    w_known = 1'b0;
    case (bus_if.opcode)
      c_OP_R, c_OP_IARITH, c_OP_LOAD, c_OP_STORE,
      c_OP_BRANCH, c_OP_JAL, c_OP_JALR, c_OP_ECALL: w_known = 1'b1;
      default:                                      w_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IF;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_i_or_d     = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_source  = 2'd0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 2'd0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'd0;
    w_alu_op     = 2'd0;

    case (state_q)
      S_IF: begin
        w_mem_read = 1'b1;
        if (bus_if.mem_ready) begin
          w_ir_write = 1'b1;
          state_d    = S_ID;
        end
      end

      S_ID: begin
        // ALUOut captures PC+imm here as the branch/JAL target
        w_alu_src_b = 2'd1;
        if (bus_if.opcode == c_OP_ECALL) begin
          if (bus_if.halt_cond) begin
            state_d = S_HALT;
          end else begin
            w_pc_write  = 1'b1;
            w_pc_source = 2'd2;
            state_d     = S_IF;
          end
        end else if (!w_known) begin
          if (HALT_ON_UNKNOWN) begin
            state_d = S_HALT;
          end else begin
            w_pc_write  = 1'b1;
            w_pc_source = 2'd2;
            state_d     = S_IF;
          end
        end else begin
          state_d = S_EX;
        end
      end

      S_EX: begin
        state_d = S_IF;
        case (bus_if.opcode)
          c_OP_R: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = 2'd2;
            state_d     = S_WB;
          end
          c_OP_IARITH: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'd1;
            w_alu_op    = 2'd2;
            state_d     = S_WB;
          end
          c_OP_LOAD, c_OP_STORE: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'd1;
            state_d     = S_MEM;
          end
          c_OP_BRANCH: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = 2'd1;
            w_pc_write  = 1'b1;
            w_pc_source = bus_if.bcond ? 2'd1 : 2'd2;
          end
          c_OP_JAL: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 2'd2;
            w_pc_write   = 1'b1;
            w_pc_source  = 2'd1;
          end
          c_OP_JALR: begin
            // rs1 already sits in A, so writing rd==rs1 this cycle is harmless
            w_alu_src_a  = 1'b1;
            w_alu_src_b  = 2'd1;
            w_reg_write  = 1'b1;
            w_mem_to_reg = 2'd2;
            w_pc_write   = 1'b1;
            w_pc_source  = 2'd0;
          end
          default: state_d = S_IF;
        endcase
      end

      S_MEM: begin
        w_i_or_d = 1'b1;
        if (bus_if.opcode == c_OP_LOAD) begin
          w_mem_read = 1'b1;
          if (bus_if.mem_ready) state_d = S_WB;
        end else if (bus_if.opcode == c_OP_STORE) begin
          w_mem_write = 1'b1;
          if (bus_if.mem_ready) begin
            w_pc_write  = 1'b1;
            w_pc_source = 2'd2;
            state_d     = S_IF;
          end
        end else begin
          state_d = S_IF;
        end
      end

      S_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = (bus_if.opcode == c_OP_LOAD) ? 2'd1 : 2'd0;
        w_pc_write   = 1'b1;
        w_pc_source  = 2'd2;
        state_d      = S_IF;
      end

      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Each instruction retires on its single pc_write cycle
  assign retired_d = w_pc_write ? retired_q + 1'b1 : retired_q;

  // Everything is forced low while reset is asserted so no strobe can escape
  assign bus_if.mem_read   = ~reset & w_mem_read;
  assign bus_if.mem_write  = ~reset & w_mem_write;
  assign bus_if.i_or_d     = ~reset & w_i_or_d;
  assign bus_if.ir_write   = ~reset & w_ir_write;
  assign bus_if.pc_write   = ~reset & w_pc_write;
  assign bus_if.pc_source  = reset ? 2'd0 : w_pc_source;
  assign bus_if.reg_write  = ~reset & w_reg_write;
  assign bus_if.mem_to_reg = reset ? 2'd0 : w_mem_to_reg;
  assign bus_if.alu_src_a  = ~reset & w_alu_src_a;
  assign bus_if.alu_src_b  = reset ? 2'd0 : w_alu_src_b;
  assign bus_if.alu_op     = reset ? 2'd0 : w_alu_op;
  assign bus_if.is_halted  = ~reset & (state_q == S_HALT);
  assign bus_if.state      = reset ? 3'd0 : state_q;
  assign bus_if.retired    = reset ? '0 : retired_q;

endmodule

`default_nettype wire

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Control FSM for the multi-cycle RV32I core. Sequences instruction fetch, register-file read, ALU use, memory access and register-file write-back.
- Drives the write enable of the 32x32 register file and all datapath mux selects. One instruction completes every 2-5 cycles, plus memory wait states.
- Sits beside the datapath. Reads opcode from IR, branch outcome from the ALU, and a ready flag from the unified memory.

Parameters:
- HALT_ON_UNKNOWN, 0, 1 = unrecognised opcode enters HALT; 0 = treat it as NOP.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- opcode  in  7  IR[6:0], stable from ID until the instruction completes
- bcond  in  1  ALU branch-taken flag, valid in EX of a branch
- halt_cond  in  1  high when x17 == 10, evaluated for ECALL
- mem_ready  in  1  memory access completes this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  latch IR
- pc_write  out  1  PC update
- pc_source  out  2  PC source: 0 = ALU result, 1 = ALUOut register, 2 = PC+4 adder
- reg_write  out  1  register file write_enable
- mem_to_reg  out  2  rd_din source: 0 = ALUOut, 1 = MDR, 2 = PC+4
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B input: 0 = register B, 1 = immediate, 2 = constant 4
- alu_op  out  2  ALU mode: 0 = add, 1 = branch compare, 2 = funct-decoded
- is_halted  out  1  FSM in HALT
- state  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5
- retired  out  CNT_W  completed-instruction count

Behaviour:
- Reset: state=IF, retired=0, is_halted=0, every output 0 during the reset cycle. Reset mid-instruction abandons it; no write strobe fires while reset is high.
- Outputs are decoded combinationally from state, opcode, mem_ready and bcond. Any output not named below is 0.
- IF: mem_read=1, i_or_d=0.
  - mem_ready=0: stay in IF.
  - mem_ready=1: ir_write=1, go to ID.
- ID: alu_src_a=0, alu_src_b=1, alu_op=0, so ALUOut <= PC+imm (branch/JAL target).
  - ECALL (1110011) with halt_cond=1: go to HALT, no pc_write.
  - ECALL with halt_cond=0: pc_write=1, pc_source=2, go to IF.
  - Unknown opcode: HALT if HALT_ON_UNKNOWN=1; else pc_write=1, pc_source=2, go to IF.
  - Any other opcode: go to EX.
- EX, by opcode:
  - R (0110011): a=1, b=0, alu_op=2; go to WB.
  - I-arith (0010011): a=1, b=1, alu_op=2; go to WB.
  - LOAD (0000011) / STORE (0100011): a=1, b=1, alu_op=0; go to MEM.
  - BRANCH (1100011): a=1, b=0, alu_op=1, pc_write=1; pc_source=1 if bcond else 2; go to IF.
  - JAL (1101111): reg_write=1, mem_to_reg=2, pc_write=1, pc_source=1; go to IF.
  - JALR (1100111): a=1, b=1, alu_op=0, reg_write=1, mem_to_reg=2, pc_write=1, pc_source=0; go to IF. rs1 is already latched in A, so rd==rs1 is safe.
- MEM: i_or_d=1.
  - LOAD: mem_read=1; hold until mem_ready=1, then go to WB (MDR latched that cycle).
  - STORE: mem_write=1; hold until mem_ready=1; in that cycle pc_write=1, pc_source=2, go to IF.
  - mem_write is held high and stable during a wait; one strobe per store.
- WB: reg_write=1, mem_to_reg = 1 for LOAD else 0, pc_write=1, pc_source=2; go to IF.
- HALT: absorbing until reset, is_halted=1, all strobes 0.
- retired increments on every cycle with pc_write=1 (exactly one per instruction) and wraps at 2^CNT_W. ECALL-halt does not increment.
- Latency with zero-wait memory (mem_ready=1 on first request): R/I 4, LOAD 5, STORE 4, BRANCH 3, JAL/JALR 3, ECALL 2 cycles. Each memory wait cycle adds 1.
- x0 protection is not this block's job; reg_write asserts even when rd=0.

Test Plan:
- Reset held 3 cycles mid-EX of an R-type → state=IF, reg_write=0 and pc_write=0 throughout; retired=0 after release.
- ADD, zero-wait memory → states IF,ID,EX,WB. reg_write=1 only in WB with mem_to_reg=0, pc_source=2; retired=1.
- LOAD with mem_ready low 2 cycles in IF and 3 in MEM → 10 cycles total. mem_read held stable; ir_write pulses once; WB mem_to_reg=1.
- BRANCH, bcond=1 then a second branch with bcond=0 → 3 cycles each; EX pc_source=1 then 2; reg_write never asserted.
- JALR → EX asserts reg_write, pc_write, mem_to_reg=2, pc_source=0 in the same cycle.
- ECALL halt_cond=0 → returns to IF after 2 cycles, retired+1. ECALL halt_cond=1 → HALT, is_halted=1, mem_ready ignored; reset returns to IF.
